// File: rtl/processorci_bus_pkg.sv
// Shared types for the core bus arbiter and related shared-bus blocks.
package processorci_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_INSTR = 1'b0,
        GRANT_DATA  = 1'b1
    } grant_t;

    // Read data returned to a master whose transaction was abandoned by the watchdog.
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational 2-way round-robin grant: on contention the master that did not win last time wins.
module rr_arbiter2
    import processorci_bus_pkg::*;
(
    input  logic   req0,
    input  logic   req1,
    input  grant_t last_grant,
    output logic   valid,
    output grant_t grant
);

    // Pick a winner from the two requests and the previous grant.
    always_comb begin
        valid = req0 | req1;
        grant = GRANT_INSTR;
        if (req0 && req1) begin
            grant = (last_grant == GRANT_INSTR) ? GRANT_DATA : GRANT_INSTR;
        end else if (req1) begin
            grant = GRANT_DATA;
        end
    end

endmodule

// File: rtl/core_bus_arbiter.sv
// Shares the Controller Wishbone port between the instruction fetch and data ports.
// One transaction in flight at a time; round-robin on contention.
// Optional watchdog compiled in with `define ARB_TIMEOUT_EN (adds timeout_o).
module core_bus_arbiter
    import processorci_bus_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_req_i,
    input  logic [ADDR_W-1:0] instr_addr_i,
    output logic [DATA_W-1:0] instr_data_o,
    output logic              instr_ack_o,
    input  logic              data_req_i,
    input  logic              data_we_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [DATA_W-1:0] data_wdata_i,
    output logic [DATA_W-1:0] data_rdata_o,
    output logic              data_ack_o,
    output logic              core_cyc_o,
    output logic              core_stb_o,
    output logic              core_we_o,
    output logic [ADDR_W-1:0] core_addr_o,
    output logic [DATA_W-1:0] core_data_o,
    input  logic [DATA_W-1:0] core_data_i,
    input  logic              core_ack_i
`ifdef ARB_TIMEOUT_EN
    ,
    output logic              timeout_o
`endif
);

    arb_state_t        state;
    arb_state_t        state_next;
    grant_t            last_grant;
    logic              arb_valid;
    grant_t            arb_grant;
    logic              instr_req_m;
    logic              data_req_m;
    logic              timeout_hit;

    logic              cyc_n;
    logic              stb_n;
    logic              we_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] wdata_n;
    logic [DATA_W-1:0] instr_rdata_n;
    logic [DATA_W-1:0] data_rdata_n;
    logic              instr_ack_n;
    logic              data_ack_n;
    logic [DATA_W-1:0] resp_data;

    // A master whose ack is pulsing cannot be granted again in that cycle.
    assign instr_req_m = instr_req_i & ~instr_ack_o;
    assign data_req_m  = data_req_i & ~data_ack_o;

    rr_arbiter2 u_rr_arbiter2 (
        .req0       (instr_req_m),
        .req1       (data_req_m),
        .last_grant (last_grant),
        .valid      (arb_valid),
        .grant      (arb_grant)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] busy_cnt;

    // Fires on the last allowed BUSY cycle; a slave ack in that cycle takes precedence.
    assign timeout_hit = (state != IDLE) && !core_ack_i &&
                         (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Watchdog counter (cleared while idle, so fresh at every grant) and timeout pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_cnt  <= '0;
            timeout_o <= 1'b0;
        end else begin
            timeout_o <= timeout_hit;
            if (state == IDLE) begin
                busy_cnt <= '0;
            end else begin
                busy_cnt <= busy_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign timeout_hit = 1'b0;

    // TIMEOUT_CYCLES only has meaning when the watchdog is compiled in.
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
    end
`endif

    // Response data: slave data normally, the marker word on a watchdog abort.
    assign resp_data = core_ack_i ? core_data_i : DATA_W'(TIMEOUT_DATA);

    // State register and round-robin history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GRANT_DATA;
        end else begin
            state <= state_next;
            if (state == IDLE && arb_valid) begin
                last_grant <= arb_grant;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (arb_valid) begin
                    state_next = (arb_grant == GRANT_INSTR) ? BUSY_I : BUSY_D;
                end
            end
            BUSY_I, BUSY_D: begin
                if (core_ack_i || timeout_hit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Next values of the registered bus and master-side outputs.
    always_comb begin
        cyc_n         = core_cyc_o;
        stb_n         = core_stb_o;
        we_n          = core_we_o;
        addr_n        = core_addr_o;
        wdata_n       = core_data_o;
        instr_rdata_n = instr_data_o;
        data_rdata_n  = data_rdata_o;
        instr_ack_n   = 1'b0;
        data_ack_n    = 1'b0;
        case (state)
            IDLE: begin
                if (arb_valid) begin
                    cyc_n = 1'b1;
                    stb_n = 1'b1;
                    if (arb_grant == GRANT_INSTR) begin
                        we_n    = 1'b0;
                        addr_n  = instr_addr_i;
                        wdata_n = '0;
                    end else begin
                        we_n    = data_we_i;
                        addr_n  = data_addr_i;
                        wdata_n = data_wdata_i;
                    end
                end
            end
            BUSY_I: begin
                if (core_ack_i || timeout_hit) begin
                    cyc_n         = 1'b0;
                    stb_n         = 1'b0;
                    instr_ack_n   = 1'b1;
                    instr_rdata_n = resp_data;
                end
            end
            BUSY_D: begin
                if (core_ack_i || timeout_hit) begin
                    cyc_n        = 1'b0;
                    stb_n        = 1'b0;
                    data_ack_n   = 1'b1;
                    data_rdata_n = resp_data;
                end
            end
            default: begin
                cyc_n = 1'b0;
                stb_n = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_cyc_o   <= 1'b0;
            core_stb_o   <= 1'b0;
            core_we_o    <= 1'b0;
            core_addr_o  <= '0;
            core_data_o  <= '0;
            instr_data_o <= '0;
            data_rdata_o <= '0;
            instr_ack_o  <= 1'b0;
            data_ack_o   <= 1'b0;
        end else begin
            core_cyc_o   <= cyc_n;
            core_stb_o   <= stb_n;
            core_we_o    <= we_n;
            core_addr_o  <= addr_n;
            core_data_o  <= wdata_n;
            instr_data_o <= instr_rdata_n;
            data_rdata_o <= data_rdata_n;
            instr_ack_o  <= instr_ack_n;
            data_ack_o   <= data_ack_n;
        end
    end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Scoreboard bench for core_bus_arbiter: transaction-level model predicts bus cycles and acks.
`timescale 1ns/1ps
module tb_core_bus_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned TO     = 8;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              instr_req = 1'b0;
    logic [ADDR_W-1:0] instr_addr = '0;
    logic [DATA_W-1:0] instr_data_o;
    logic              instr_ack_o;
    logic              data_req = 1'b0;
    logic              data_we = 1'b0;
    logic [ADDR_W-1:0] data_addr = '0;
    logic [DATA_W-1:0] data_wdata = '0;
    logic [DATA_W-1:0] data_rdata_o;
    logic              data_ack_o;
    logic              core_cyc_o, core_stb_o, core_we_o;
    logic [ADDR_W-1:0] core_addr_o;
    logic [DATA_W-1:0] core_data_o;
    logic [DATA_W-1:0] core_data_i = '0;
    logic              core_ack_i = 1'b0;
`ifdef ARB_TIMEOUT_EN
    logic              timeout_o;
`endif

    always #5 clk = ~clk;

    core_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .instr_req_i(instr_req), .instr_addr_i(instr_addr),
        .instr_data_o(instr_data_o), .instr_ack_o(instr_ack_o),
        .data_req_i(data_req), .data_we_i(data_we), .data_addr_i(data_addr),
        .data_wdata_i(data_wdata), .data_rdata_o(data_rdata_o), .data_ack_o(data_ack_o),
        .core_cyc_o(core_cyc_o), .core_stb_o(core_stb_o), .core_we_o(core_we_o),
        .core_addr_o(core_addr_o), .core_data_o(core_data_o),
        .core_data_i(core_data_i), .core_ack_i(core_ack_i)
`ifdef ARB_TIMEOUT_EN
        , .timeout_o(timeout_o)
`endif
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct { bit m; bit we; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] wdata; } bus_tx_t;
    typedef struct { bit m; logic [DATA_W-1:0] rdata; bit to; } resp_t;
    bus_tx_t bus_q[$];
    resp_t   resp_q[$];
    bit      ack_order[$];

    // Stimulus configuration (written only by the main sequence).
    int unsigned i_limit = 0, d_limit = 0, gap_max = 0;
    bit i_fix = 0, d_fix = 0, d_fix_we = 0, drop_en = 0, late_en = 0;
    logic [31:0] i_fix_addr = '0, d_fix_addr = '0, d_fix_wdata = '0;
    int s_fixed_delay = -1;
    bit s_fix_data = 0, s_mute = 0, s_spurious = 0;
    logic [31:0] s_data = '0;

    // Model state: one transaction in flight, round-robin history (1 = data won last).
    bit m_busy = 0, m_win = 0, m_last = 1, m_ackcyc_i = 0, m_ackcyc_d = 0;
    int m_busy_cyc = 0;

    // Reference model: grants at clock edges, completes on slave ack or watchdog expiry.
    always @(posedge clk or posedge rst) begin
        bit pi, pd, ai, ad, fin, tmo;
        if (rst) begin
            m_busy = 0; m_last = 1; m_ackcyc_i = 0; m_ackcyc_d = 0;
            bus_q.delete(); resp_q.delete();
        end else begin
            pi = instr_req && !m_ackcyc_i;
            pd = data_req && !m_ackcyc_d;
            ai = 0; ad = 0; fin = 0; tmo = 0;
            if (m_busy) begin
                m_busy_cyc++;
                if (core_ack_i) fin = 1;
                else if (TO_EN && m_busy_cyc == int'(TO)) begin fin = 1; tmo = 1; end
                if (fin) begin
                    resp_q.push_back('{m: m_win, rdata: tmo ? 32'hDEADBEEF : core_data_i, to: tmo});
                    if (m_win) ad = 1; else ai = 1;
                    m_busy = 0;
                end
            end else if (pi || pd) begin
                m_win = (pi && pd) ? !m_last : pd;
                m_last = m_win;
                m_busy = 1;
                m_busy_cyc = 0;
                if (m_win) bus_q.push_back('{m: 1'b1, we: data_we, addr: data_addr, wdata: data_wdata});
                else       bus_q.push_back('{m: 1'b0, we: 1'b0, addr: instr_addr, wdata: '0});
            end
            m_ackcyc_i = ai;
            m_ackcyc_d = ad;
        end
    end

    // Monitor: compare bus cycles and master acks against the model's queues.
    bit prev_cyc = 0;
    bus_tx_t cur;
    resp_t r;
    logic [DATA_W-1:0] exp_i = '0, exp_d = '0;
    int instr_acks = 0, data_acks = 0;
    always @(negedge clk) begin
        if (rst) begin
            prev_cyc = 0; exp_i = '0; exp_d = '0;
        end else begin
            check("stb_eq_cyc", 64'(core_stb_o), 64'(core_cyc_o));
            if (core_cyc_o && !prev_cyc) begin
                check("bus_expected", 64'(bus_q.size() != 0), 64'(1));
                if (bus_q.size() != 0) begin
                    cur = bus_q.pop_front();
                    check("bus_we", 64'(core_we_o), 64'(cur.we));
                    check("bus_addr", 64'(core_addr_o), 64'(cur.addr));
                    check("bus_wdata", 64'(core_data_o), 64'(cur.wdata));
                end
            end else if (core_cyc_o) begin
                check("bus_stable", {core_we_o, core_addr_o, core_data_o}, {cur.we, cur.addr, cur.wdata});
            end
            if (instr_ack_o || data_ack_o) begin
                check("single_ack", 64'(instr_ack_o & data_ack_o), 64'(0));
                check("cyc_low_in_ack", 64'(core_cyc_o), 64'(0));
                check("ack_expected", 64'(resp_q.size() != 0), 64'(1));
                if (data_ack_o) data_acks++; else instr_acks++;
                ack_order.push_back(data_ack_o);
                if (resp_q.size() != 0) begin
                    r = resp_q.pop_front();
                    check("ack_master", 64'(data_ack_o), 64'(r.m));
                    if (r.m) exp_d = r.rdata; else exp_i = r.rdata;
`ifdef ARB_TIMEOUT_EN
                    check("timeout_flag", 64'(timeout_o), 64'(r.to));
`endif
                end
            end else begin
`ifdef ARB_TIMEOUT_EN
                check("timeout_idle", 64'(timeout_o), 64'(0));
`endif
            end
            check("instr_rdata", 64'(instr_data_o), 64'(exp_i));
            check("data_rdata", 64'(data_rdata_o), 64'(exp_d));
            prev_cyc = core_cyc_o;
        end
    end

    // Wishbone slave: acks after a configurable delay; optional spurious acks while idle.
    int s_wait = -1;
    always @(negedge clk) begin
        if (rst) begin
            core_ack_i = 0; s_wait = -1;
        end else begin
            core_ack_i = 0;
            if (core_cyc_o && core_stb_o && !s_mute) begin
                if (s_wait < 0) s_wait = (s_fixed_delay >= 0) ? s_fixed_delay : int'($urandom_range(0, 3));
                if (s_wait == 0) begin
                    core_ack_i = 1;
                    core_data_i = s_fix_data ? s_data : $urandom;
                    s_wait = -1;
                end else s_wait--;
            end else if (!core_cyc_o && s_spurious && $urandom_range(0, 7) == 0) begin
                core_ack_i = 1;
                core_data_i = $urandom;
            end
        end
    end

    // Instruction master: holds req until ack; may keep req through the ack cycle or drop early.
    int unsigned i_issued = 0, d_issued = 0;
    int i_gap = 0, d_gap = 0;
    bit i_stale = 0, i_late = 0, d_stale = 0, d_late = 0;
    always @(negedge clk) begin
        if (rst) begin
            instr_req = 0; i_stale = 0; i_late = 0; i_gap = 0;
        end else if (i_late) begin
            instr_req = 0; i_late = 0; i_gap = int'($urandom_range(0, gap_max));
        end else if (instr_req || i_stale) begin
            if (instr_ack_o) begin
                i_stale = 0;
                if (instr_req && late_en && $urandom_range(0, 1) == 1) i_late = 1;
                else begin instr_req = 0; i_gap = int'($urandom_range(0, gap_max)); end
            end else if (instr_req && drop_en && m_busy && !m_win && $urandom_range(0, 15) == 0) begin
                instr_req = 0; i_stale = 1;
            end
        end else if (i_gap > 0) i_gap--;
        else if (i_issued < i_limit) begin
            instr_req = 1;
            instr_addr = i_fix ? i_fix_addr : $urandom;
            i_issued++;
        end
    end

    // Data master: same protocol, random load/store.
    always @(negedge clk) begin
        if (rst) begin
            data_req = 0; d_stale = 0; d_late = 0; d_gap = 0;
        end else if (d_late) begin
            data_req = 0; d_late = 0; d_gap = int'($urandom_range(0, gap_max));
        end else if (data_req || d_stale) begin
            if (data_ack_o) begin
                d_stale = 0;
                if (data_req && late_en && $urandom_range(0, 1) == 1) d_late = 1;
                else begin data_req = 0; d_gap = int'($urandom_range(0, gap_max)); end
            end else if (data_req && drop_en && m_busy && m_win && $urandom_range(0, 15) == 0) begin
                data_req = 0; d_stale = 1;
            end
        end else if (d_gap > 0) d_gap--;
        else if (d_issued < d_limit) begin
            data_req = 1;
            data_we = d_fix ? d_fix_we : 1'($urandom_range(0, 1));
            data_addr = d_fix ? d_fix_addr : $urandom;
            data_wdata = d_fix ? d_fix_wdata : $urandom;
            d_issued++;
        end
    end

    task automatic wait_acks(input int ti, input int td, input int budget, input string name);
        int n = 0;
        while ((instr_acks < ti || data_acks < td) && n < budget) begin
            @(negedge clk); #1; n++;
        end
        check({name, "_instr_acks"}, 64'(instr_acks), 64'(ti));
        check({name, "_data_acks"}, 64'(data_acks), 64'(td));
    endtask

    task automatic drain(input string name);
        int n = 0;
        i_limit = i_issued; d_limit = d_issued;
        while ((instr_req || data_req || i_stale || d_stale || i_late || d_late ||
                core_cyc_o || resp_q.size() != 0) && n < 200) begin
            @(negedge clk); #1; n++;
        end
        check(name, 64'(n < 200), 64'(1));
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk); #1 rst = 1;
        repeat (2) @(negedge clk);
        #1 rst = 0;
    endtask

    initial begin #500000; $display("FAIL global_watchdog actual=running required=finished"); $fatal(1); end

    initial begin
        int base, ia, da, n;
        logic [DATA_W-1:0] rd;

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        check("rst_cyc", 64'(core_cyc_o), 64'(0));
        check("rst_stb", 64'(core_stb_o), 64'(0));
        check("rst_we", 64'(core_we_o), 64'(0));
        check("rst_addr", 64'(core_addr_o), 64'(0));
        check("rst_wdata", 64'(core_data_o), 64'(0));
        check("rst_instr_ack", 64'(instr_ack_o), 64'(0));
        check("rst_data_ack", 64'(data_ack_o), 64'(0));
        check("rst_instr_data", 64'(instr_data_o), 64'(0));
        check("rst_data_rdata", 64'(data_rdata_o), 64'(0));
        rst = 0;

        // Instruction-only read, slave replies 0x13 after a fixed delay.
        s_fixed_delay = 2; s_fix_data = 1; s_data = 32'h0000_0013;
        i_fix = 1; i_fix_addr = 32'h0000_0010;
        i_limit = i_issued + 1;
        wait_acks(1, 0, 40, "ifetch");
        check("ifetch_rdata", 64'(instr_data_o), 64'(32'h13));
        drain("ifetch_drain");
        check("ifetch_single_ack", 64'(instr_acks), 64'(1));
        s_fix_data = 0; i_fix = 0;

        // Data store.
        d_fix = 1; d_fix_we = 1; d_fix_addr = 32'h0000_1000; d_fix_wdata = 32'hCAFE_BABE;
        d_limit = d_issued + 1;
        n = 0;
        while (!core_cyc_o && n < 20) begin @(negedge clk); #1; n++; end
        check("store_we", 64'(core_we_o), 64'(1));
        check("store_addr", 64'(core_addr_o), 64'(32'h1000));
        check("store_wdata", 64'(core_data_o), 64'(32'hCAFE_BABE));
        wait_acks(1, 1, 40, "store");
        drain("store_drain");
        d_fix = 0;

        // Continuous contention after reset alternates I, D, I, D.
        pulse_reset();
        s_fixed_delay = -1;
        base = ack_order.size();
        ia = instr_acks; da = data_acks;
        i_limit = i_issued + 1000; d_limit = d_issued + 1000;
        n = 0;
        while (ack_order.size() < base + 4 && n < 100) begin @(negedge clk); #1; n++; end
        check("alternate_count", 64'(ack_order.size() >= base + 4), 64'(1));
        if (ack_order.size() >= base + 4)
            for (int k = 0; k < 4; k++) check("alternate_grant", 64'(ack_order[base + k]), 64'(k % 2));
        drain("alternate_drain");

        // Reset while a data read is outstanding.
        s_mute = 1;
        d_fix = 1; d_fix_we = 0; d_fix_addr = 32'h0000_2000; d_fix_wdata = '0;
        d_limit = d_issued + 1;
        n = 0;
        while (!core_cyc_o && n < 20) begin @(negedge clk); #1; n++; end
        check("busy_d_cyc", 64'(core_cyc_o), 64'(1));
        @(posedge clk); #1 rst = 1;
        #1;
        check("midrst_cyc", 64'(core_cyc_o), 64'(0));
        check("midrst_stb", 64'(core_stb_o), 64'(0));
        check("midrst_acks", {62'd0, instr_ack_o, data_ack_o}, 64'(0));
        repeat (2) @(negedge clk);
        #1 rst = 0; s_mute = 0; d_fix = 0;
        ia = instr_acks; da = data_acks;
        repeat (5) @(negedge clk);
        #1;
        check("midrst_no_ack", 64'(instr_acks + data_acks), 64'(ia + da));
        base = ack_order.size();
        i_limit = i_issued + 1; d_limit = d_issued + 1;
        wait_acks(ia + 1, da + 1, 60, "post_rst");
        if (ack_order.size() >= base + 2) begin
            check("post_rst_first_instr", 64'(ack_order[base]), 64'(0));
            check("post_rst_second_data", 64'(ack_order[base + 1]), 64'(1));
        end
        drain("post_rst_drain");

`ifdef ARB_TIMEOUT_EN
        // Watchdog: slave never acks a data read.
        s_mute = 1;
        d_fix = 1; d_fix_we = 0; d_fix_addr = 32'h0000_3000;
        da = data_acks;
        d_limit = d_issued + 1;
        n = 0;
        while (!data_ack_o && n < 40) begin
            @(negedge clk); #1;
            if (core_cyc_o) n++;
            if (!core_cyc_o && !data_req) n = 40;
        end
        check("timeout_busy_cycles", 64'(n), 64'(TO));
        check("timeout_pulse", 64'(timeout_o), 64'(1));
        check("timeout_ack", 64'(data_ack_o), 64'(1));
        rd = data_rdata_o;
        check("timeout_rdata", 64'(rd), 64'(32'hDEADBEEF));
        s_mute = 0; d_fix = 0;
        drain("timeout_drain");
        check("timeout_idle_cyc", 64'(core_cyc_o), 64'(0));
`endif

        // Randomised traffic: gaps, late req drop, early abandon, spurious idle acks.
        gap_max = 3; late_en = 1; drop_en = 1; s_spurious = 1; s_fixed_delay = -1;
        ia = instr_acks; da = data_acks;
        i_limit = i_issued + 100000; d_limit = d_issued + 100000;
        repeat (1500) @(negedge clk);
        #1;
        s_spurious = 0;
        drain("random_drain");
        check("random_traffic", 64'((instr_acks - ia) > 20 && (data_acks - da) > 20), 64'(1));
        check("final_bus_q_empty", 64'(bus_q.size()), 64'(0));
        check("final_resp_q_empty", 64'(resp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
